// File: rtl/instr_loader_pkg.sv
// Shared instruction-memory geometry and loader state encodings.
// Other stages use the LOADER_* values to decode loader state in debug prints.
package instr_loader_pkg;

  localparam int unsigned WORD_SIZE      = 16;
  localparam int unsigned IMEM_ADDR_SIZE = 8;
  localparam int unsigned IMEM_DEPTH     = 256;

  localparam logic [1:0] LOADER_IDLE  = 2'd0;
  localparam logic [1:0] LOADER_LOAD  = 2'd1;
  localparam logic [1:0] LOADER_DONE  = 2'd2;
  localparam logic [1:0] LOADER_ERROR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = LOADER_IDLE,
    ST_LOAD  = LOADER_LOAD,
    ST_DONE  = LOADER_DONE,
    ST_ERROR = LOADER_ERROR
  } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Program-word stream in and instruction-memory write port out.
// master is the host/memory side, slave is the loader.
interface instr_loader_if #(
  parameter int unsigned WORD_SIZE = instr_loader_pkg::WORD_SIZE,
  parameter int unsigned ADDR_SIZE = instr_loader_pkg::IMEM_ADDR_SIZE
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;
  logic                 in_last;

  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_data
  );

endinterface

// File: rtl/instr_loader.sv
// Program loader: streams words into instruction memory from address 0,
// holds the CPU until the load completes, and keeps an XOR checksum.
module instr_loader #(
  parameter int unsigned WORD_SIZE = instr_loader_pkg::WORD_SIZE,
  parameter int unsigned ADDR_SIZE = instr_loader_pkg::IMEM_ADDR_SIZE,
  parameter int unsigned MEM_DEPTH = instr_loader_pkg::IMEM_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  instr_loader_if.slave        bus,
  output logic                 cpu_run,
  output logic [ADDR_SIZE:0]   load_count,
  output logic [WORD_SIZE-1:0] checksum,
  output logic                 error
);

  import instr_loader_pkg::*;

  localparam int unsigned CNT_W = ADDR_SIZE + 1;
  // Index of the last writable word; accepting it without in_last overflows.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MEM_DEPTH - 1);

  loader_state_t state, state_next;
  logic          take_c;
  logic          ready_nxt;
  logic          run_nxt;
  logic          error_nxt;

  // Next state plus the next values of the state-decoded flag outputs.
  always_comb begin
    state_next = state;
    take_c     = 1'b0;
    ready_nxt  = 1'b0;
    run_nxt    = 1'b0;
    error_nxt  = 1'b0;

    take_c = (state == ST_LOAD) && bus.in_valid && bus.in_ready;

    if (start) begin
      state_next = ST_LOAD;
    end else if (take_c) begin
      if (bus.in_last) begin
        state_next = ST_DONE;
      end else if (load_count == LAST_IDX) begin
        state_next = ST_ERROR;
      end
    end

    ready_nxt = (state_next == ST_LOAD);
    run_nxt   = (state_next == ST_DONE);
    error_nxt = (state_next == ST_ERROR);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs; load_count doubles as the write-address counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.in_ready <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      cpu_run      <= 1'b0;
      load_count   <= '0;
      checksum     <= '0;
      error        <= 1'b0;
    end else begin
      bus.in_ready <= ready_nxt;
      cpu_run      <= run_nxt;
      error        <= error_nxt;
      bus.mem_we   <= 1'b0;
      // start wins over a word accepted in the same cycle.
      if (start) begin
        load_count <= '0;
        checksum   <= '0;
      end else if (take_c) begin
        bus.mem_we   <= 1'b1;
        bus.mem_addr <= load_count[ADDR_SIZE-1:0];
        bus.mem_data <= bus.in_data;
        load_count   <= load_count + CNT_W'(1);
        checksum     <= checksum ^ bus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader with a small memory depth: the driver
// pushes expected writes on each accept, a monitor checks every mem_we.
module tb_instr_loader;

  localparam int unsigned WS    = 16;
  localparam int unsigned AS    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = AS + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          cpu_run;
  logic          error;
  logic [CW-1:0] load_count;
  logic [WS-1:0] checksum;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [AS+WS-1:0] exp_q[$];
  int               acc_q[$];
  logic [WS-1:0]    prog[$];
  logic [AS+WS-1:0] mon_e;
  int               mon_c;

  instr_loader_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus ();

  instr_loader #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .MEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .cpu_run    (cpu_run),
    .load_count (load_count),
    .checksum   (checksum),
    .error      (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every write must match the next accepted word, one cycle later.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 bus.mem_addr, bus.mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = acc_q.pop_front();
        chk("write_addr", 32'(bus.mem_addr), 32'(mon_e[AS+WS-1:WS]));
        chk("write_data", 32'(bus.mem_data), 32'(mon_e[WS-1:0]));
        chk("write_latency", cyc, mon_c);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_ready", 32'(bus.in_ready), 1);
    chk("start_run", 32'(cpu_run), 0);
    chk("start_error", 32'(error), 0);
    chk("start_count", 32'(load_count), 0);
    chk("start_checksum", 32'(checksum), 0);
  endtask

  // Reference: a load keeps at most DEPTH words; it completes only if in_last
  // arrives within them, and otherwise errors once DEPTH words are taken.
  task automatic run_load(input int n, input bit has_last, input int bmin, input int bmax);
    int            kept;
    logic [WS-1:0] ck;
    bit            ok;
    bit            exp_run, exp_err, exp_rdy;
    kept = (n < int'(DEPTH)) ? n : int'(DEPTH);
    ck = '0;
    for (int i = 0; i < kept; i++) ck ^= prog[i];
    pulse_start();
    for (int i = 0; i < n; i++) begin
      repeat (int'($urandom_range(32'(bmax), 32'(bmin)))) begin
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = prog[i];
      bus.in_last  = has_last && (i == n - 1);
      ok = 1'b0;
      for (int t = 0; t < 12 && !ok; t++) begin
        @(negedge clk);
        chk("run_low_while_loading", 32'(cpu_run), 0);
        if (bus.in_ready === 1'b1) begin
          @(posedge clk); #1;
          ok = 1'b1;
          exp_q.push_back({AS'(i), prog[i]});
          acc_q.push_back(cyc);
        end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("word_accepted", 32'(ok), 32'(i < kept));
    end
    if (has_last && n <= int'(DEPTH)) begin
      exp_run = 1'b1; exp_err = 1'b0; exp_rdy = 1'b0;
    end else if (n >= int'(DEPTH)) begin
      exp_run = 1'b0; exp_err = 1'b1; exp_rdy = 1'b0;
    end else begin
      exp_run = 1'b0; exp_err = 1'b0; exp_rdy = 1'b1;
    end
    @(negedge clk);
    chk("end_run", 32'(cpu_run), 32'(exp_run));
    chk("end_error", 32'(error), 32'(exp_err));
    chk("end_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("end_count", 32'(load_count), kept);
    chk("end_checksum", 32'(checksum), 32'(ck));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit hl;
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_data", 32'(bus.mem_data), 0);
    chk("rst_run", 32'(cpu_run), 0);
    chk("rst_count", 32'(load_count), 0);
    chk("rst_checksum", 32'(checksum), 0);
    chk("rst_error", 32'(error), 0);

    // Words offered while idle are never taken.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hAAAA;
    bus.in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", 32'(bus.in_ready), 0);
      chk("idle_we", 32'(bus.mem_we), 0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    prog = {16'h1111, 16'h2222, 16'h3333};
    run_load(3, 1'b1, 0, 0);

    prog = {16'h00FF, 16'h0F0F};
    run_load(2, 1'b1, 1, 1);

    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back(WS'($urandom));
    run_load(5, 1'b0, 0, 1);

    prog.delete();
    for (int i = 0; i < 4; i++) prog.push_back(WS'($urandom));
    run_load(4, 1'b1, 0, 0);
    run_load(3, 1'b1, 0, 2);

    // start colliding with an accepted word discards that word.
    pulse_start();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("collide_we", 32'(bus.mem_we), 0);
    chk("collide_count", 32'(load_count), 0);
    chk("collide_checksum", 32'(checksum), 0);
    chk("collide_ready", 32'(bus.in_ready), 1);

    // Reset part way through a four-word load.
    prog.delete();
    for (int i = 0; i < 4; i++) prog.push_back(WS'($urandom));
    run_load(2, 1'b0, 0, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = prog[2];
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_we", 32'(bus.mem_we), 0);
    chk("midrst_count", 32'(load_count), 0);
    chk("midrst_ready", 32'(bus.in_ready), 0);
    chk("midrst_run", 32'(cpu_run), 0);
    chk("midrst_checksum", 32'(checksum), 0);

    repeat (12) begin
      n  = int'($urandom_range(6, 1));
      hl = 1'($urandom_range(1, 0));
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(WS'($urandom));
      run_load(n, hl, 0, 2);
    end

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Program loader and the write side of instruction memory. It accepts a stream of program words over a valid/ready handshake and writes them to consecutive instruction-memory addresses starting at 0. It holds the CPU in a not-running state until the load completes, then releases it so the fetch stage can read the loaded program. It also keeps a running XOR checksum of the loaded words for host-side verification.

Parameters:
WORD_SIZE, 16, instruction/data word width in bits; shared value from the common parameters include.
ADDR_SIZE, 8, instruction-memory address width in bits.
MEM_DEPTH, 256, number of writable words; must be at most 2**ADDR_SIZE.

Ports:
clk  input  1  system clock; all logic updates on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse that begins (or restarts) a load.
in_valid  input  1  in_data/in_last hold a word.
in_ready  output  1  loader will accept a word this cycle.
in_data  input  WORD_SIZE  program word.
in_last  input  1  marks the final word of the program.
mem_we  output  1  instruction-memory write strobe.
mem_addr  output  ADDR_SIZE  write address.
mem_data  output  WORD_SIZE  write data.
cpu_run  output  1  high = CPU may fetch and execute.
load_count  output  ADDR_SIZE+1  number of words written in the current or last load.
checksum  output  WORD_SIZE  XOR of all words accepted in the current or last load.
error  output  1  overflow: the load exceeded MEM_DEPTH words.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset, and is sampled at posedge clk.
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_run=0, load_count=0, checksum=0, error=0. Reset mid-load abandons the load; words already written stay in memory.
- States and per-state outputs:
  - IDLE: in_ready=0, cpu_run=0.
  - LOAD: in_ready=1, cpu_run=0.
  - DONE: in_ready=0, cpu_run=1.
  - ERROR: in_ready=0, cpu_run=0, error=1.
- start: in any non-reset state, start clears load_count, checksum, error and the internal address counter, and moves to LOAD on the next edge. In DONE this drops cpu_run on that same edge. start has priority over a word accepted in the same cycle; that word is discarded.
- Accept: a word is accepted when in_valid && in_ready at posedge.
- Write latency: exactly 1 cycle. On the edge after an accept: mem_we=1, mem_addr=address counter, mem_data=word. On that same edge: address counter +1, load_count +1, checksum ^= word.
- mem_we: low in every cycle that does not follow an accept.
- Back-to-back: one accept per cycle sustains one write per cycle.
- Completion: an accept with in_last=1 moves LOAD to DONE. cpu_run rises on the same edge the final write is issued.
- Overflow: an accept of word index MEM_DEPTH-1 (load_count becoming MEM_DEPTH) with in_last=0 writes that word, then moves to ERROR. The address counter never wraps, and no write to an address >= MEM_DEPTH is ever issued.
- Exact fit: an accept of word MEM_DEPTH-1 with in_last=1 goes to DONE with no error.
- in_last outside LOAD is ignored.
- in_valid outside LOAD is not accepted (in_ready=0); the source holds its data.
- load_count, checksum: hold their values in DONE and ERROR until the next start or reset.

Decomposition:
- Shared include: WORD_SIZE and the instruction-memory address width and depth, alongside the existing word-size parameter. Add the loader state encodings (IDLE=0, LOAD=1, DONE=2, ERROR=3) as localparams there, so that debug $display in other stages can decode them.
- Sub-modules: none required. The address counter and checksum register live in the top module. An optional instance of the existing instruction memory may be wired in a wrapper, not inside this block.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> all outputs 0. Drive in_valid=1 in IDLE -> in_ready=0, mem_we=0, nothing accepted.
- Three-word load: start, then 0x1111, 0x2222, 0x3333 (last) back-to-back -> writes to addr 0,1,2 on consecutive cycles, one cycle after each accept. Then cpu_run=1, load_count=3, checksum=0x0000.
- Bubbles and stall: in_valid toggled 1,0,1(last) with words 0x00FF, 0x0F0F -> exactly 2 writes, checksum=0x0FF0, cpu_run=1 only after the second write.
- Overflow: MEM_DEPTH=4, five words, no in_last -> writes to addr 0..3, then error=1, cpu_run=0, in_ready=0. The fifth word is not accepted; a subsequent start clears error.
- Restart and reset mid-load: start in DONE -> cpu_run falls next edge, addr restarts at 0. Reset asserted after 2 of 4 words -> IDLE, mem_we=0 next cycle, load_count=0.
- Exact fit with start collision: MEM_DEPTH=4, 4 words with last on the 4th -> DONE, error=0. A start coincident with an accepted word -> that word is not written, load_count=0.
